// File: rtl/ml_dsa_pkg.sv
// rtl/ml_dsa_pkg.sv - ML-DSA modulus constants, coefficient types and modular helpers
package ml_dsa_pkg;

    localparam int WIDTH = 23;
    localparam int Q     = 8380417;
    localparam int LAT   = 4;

    typedef logic [WIDTH-1:0] coeff_t;

    typedef enum logic {
        BT_CT = 1'b0,
        BT_GS = 1'b1
    } bt_mode_t;

    localparam logic [WIDTH:0] Q_X = (WIDTH+1)'(Q);

    function automatic coeff_t mod_add(input coeff_t a, input coeff_t b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_X) s = s - Q_X;
        return coeff_t'(s);
    endfunction

    function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b);
        logic [WIDTH:0] d;
        d = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + Q_X - {1'b0, b};
        return coeff_t'(d);
    endfunction

    // Odd values borrow one Q so the halving stays exact modulo Q.
    function automatic coeff_t mod_half(input coeff_t a);
        logic [WIDTH:0] h;
        h = a[0] ? ({1'b0, a} + Q_X) >> 1 : {1'b0, a} >> 1;
        return coeff_t'(h);
    endfunction

endpackage

// File: rtl/mod_mul_barrett.sv
// rtl/mod_mul_barrett.sv - 3-stage pipelined Barrett modular multiplier, r = a*b mod Q
module mod_mul_barrett #(
    parameter int WIDTH = 23,
    parameter int Q     = 8380417
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [W2:0]      POW  = {1'b1, {W2{1'b0}}};
    localparam logic [W2:0]      MU   = POW / (W2+1)'(Q);
    localparam logic [2*W2:0]    MU_X = (2*W2+1)'(MU);
    localparam logic [WIDTH+1:0] Q_R  = (WIDTH+2)'(Q);

    logic [W2-1:0]    p_q, p_d;
    logic [WIDTH+1:0] r_q, r_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [2*W2:0]    pm;
    logic [WIDTH:0]   t;
    logic [WIDTH+1:0] c1, c2;

    // The Barrett estimate undershoots by at most 2, so r < 3Q needs two corrections.
    always_comb begin
        p_d   = W2'(a) * W2'(b);
        pm    = (2*W2+1)'(p_q) * MU_X;
        t     = (WIDTH+1)'(pm >> W2);
        r_d   = (WIDTH+2)'(p_q - W2'(t) * W2'(Q));
        c1    = (r_q >= Q_R) ? r_q - Q_R : r_q;
        c2    = (c1 >= Q_R) ? c1 - Q_R : c1;
        res_d = WIDTH'(c2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q   <= '0;
            r_q   <= '0;
            res_q <= '0;
        end else begin
            p_q   <= p_d;
            r_q   <= r_d;
            res_q <= res_d;
        end
    end

    assign r = res_q;

endmodule

// File: rtl/bt_unit_pipe.sv
// rtl/bt_unit_pipe.sv - pipelined CT/GS modular butterfly, one butterfly per cycle, LAT=4
module bt_unit_pipe #(
    parameter int WIDTH = ml_dsa_pkg::WIDTH,
    parameter int Q     = ml_dsa_pkg::Q
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             div2,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic [WIDTH-1:0] zeta,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             valid
);

    localparam int LAT = ml_dsa_pkg::LAT;
    localparam logic [WIDTH:0] QW = (WIDTH+1)'(Q);

    logic [LAT:0]            vld_q, vld_d;
    logic [WIDTH-1:0]        x1_q, x1_d, y1_q, y1_d, z1_q, z1_d;
    logic                    gs1_q, gs1_d, h1_q, h1_d;
    logic [2:0][WIDTH-1:0]   xd_q, xd_d;
    logic [2:0]              gsd_q, gsd_d, hd_q, hd_d;
    logic [WIDTH-1:0]        a_out_q, a_out_d, b_out_q, b_out_d;
    logic [WIDTH-1:0]        m;
    logic [WIDTH:0]          ax, bx, sum, dif, x, mx, add, sub, ra, rb;

    function automatic logic [WIDTH:0] half_mod(input logic [WIDTH:0] v);
        return v[0] ? (v + QW) >> 1 : v >> 1;
    endfunction

    mod_mul_barrett #(.WIDTH(WIDTH), .Q(Q)) u_mul (
        .clk   (clk),
        .reset (reset),
        .a     (z1_q),
        .b     (y1_q),
        .r     (m)
    );

    // GS folds A+B and A-B into S1 so the multiplier always sees zeta*operand.
    always_comb begin
        ax    = {1'b0, A_in};
        bx    = {1'b0, B_in};
        sum   = ax + bx;
        if (sum >= QW) sum = sum - QW;
        dif   = (ax >= bx) ? ax - bx : ax + QW - bx;
        gs1_d = (ml_dsa_pkg::bt_mode_t'(mode) == ml_dsa_pkg::BT_GS);
        h1_d  = div2 & gs1_d;
        x1_d  = gs1_d ? WIDTH'(sum) : A_in;
        y1_d  = gs1_d ? WIDTH'(dif) : B_in;
        z1_d  = zeta;
        vld_d = {vld_q[LAT-1:0], en};
        xd_d  = {xd_q[1:0], x1_q};
        gsd_d = {gsd_q[1:0], gs1_q};
        hd_d  = {hd_q[1:0], h1_q};
    end

    always_comb begin
        x   = {1'b0, xd_q[2]};
        mx  = {1'b0, m};
        add = x + mx;
        if (add >= QW) add = add - QW;
        sub = (x >= mx) ? x - mx : x + QW - mx;
        ra  = add;
        rb  = sub;
        if (gsd_q[2]) begin
            ra = hd_q[2] ? half_mod(x) : x;
            rb = hd_q[2] ? half_mod(mx) : mx;
        end
        a_out_d = vld_q[LAT-1] ? WIDTH'(ra) : a_out_q;
        b_out_d = vld_q[LAT-1] ? WIDTH'(rb) : b_out_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q   <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            z1_q    <= '0;
            gs1_q   <= 1'b0;
            h1_q    <= 1'b0;
            xd_q    <= '0;
            gsd_q   <= '0;
            hd_q    <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            vld_q   <= vld_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            z1_q    <= z1_d;
            gs1_q   <= gs1_d;
            h1_q    <= h1_d;
            xd_q    <= xd_d;
            gsd_q   <= gsd_d;
            hd_q    <= hd_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
        end
    end

    assign A_out = a_out_q;
    assign B_out = b_out_q;
    assign valid = vld_q[LAT];

endmodule

// File: tb/tb_bt_unit_pipe.sv
// tb/tb_bt_unit_pipe.sv - randomized self-checking bench for bt_unit_pipe against a modular-arithmetic model
module tb_bt_unit_pipe;

    localparam longint QM  = 8380417;
    localparam int     LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic        div2 = 1'b0;
    logic [22:0] A_in = '0;
    logic [22:0] B_in = '0;
    logic [22:0] zeta = '0;
    logic [22:0] A_out;
    logic [22:0] B_out;
    logic        valid;

    always #5 clk = ~clk;

    bt_unit_pipe dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .div2  (div2),
        .A_in  (A_in),
        .B_in  (B_in),
        .zeta  (zeta),
        .A_out (A_out),
        .B_out (B_out),
        .valid (valid)
    );

    typedef struct {
        bit     v;
        longint a;
        longint b;
    } tok_t;

    tok_t   pipe_q[$];
    longint hold_a = 0;
    longint hold_b = 0;
    int     n_vec = 0;
    int     n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint half_ref(input longint x);
        return (x % 2 == 0) ? x / 2 : (x + QM) / 2;
    endfunction

    function automatic void bt_ref(input bit m, input bit d2, input longint a, input longint b,
                                   input longint z, output longint ra, output longint rb);
        longint t;
        if (!m) begin
            t  = (z * b) % QM;
            ra = (a + t) % QM;
            rb = (a - t + QM) % QM;
        end else begin
            ra = (a + b) % QM;
            rb = (((a - b + QM) % QM) * z) % QM;
            if (d2) begin
                ra = half_ref(ra);
                rb = half_ref(rb);
            end
        end
    endfunction

    task automatic pipe_clear();
        tok_t t;
        t.v = 1'b0; t.a = 0; t.b = 0;
        pipe_q.delete();
        repeat (LAT) pipe_q.push_back(t);
        hold_a = 0;
        hold_b = 0;
    endtask

    task automatic step(input bit e, input bit m, input bit d2, input longint a, input longint b,
                        input longint z, input longint ea, input longint eb);
        tok_t t, o;
        en   = e;
        mode = m;
        div2 = d2;
        A_in = 23'(a);
        B_in = 23'(b);
        zeta = 23'(z);
        @(posedge clk);
        t.v = e; t.a = ea; t.b = eb;
        pipe_q.push_back(t);
        o = pipe_q.pop_front();
        #1;
        chk("valid", {63'd0, valid}, {63'd0, o.v});
        if (o.v) begin
            hold_a = o.a;
            hold_b = o.b;
        end
        chk("A_out", 64'(A_out), 64'(hold_a));
        chk("B_out", 64'(B_out), 64'(hold_b));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd_step(input bit e, input bit m);
        longint a, b, z, ra, rb;
        bit     d2;
        d2 = 1'($urandom_range(0, 1));
        a  = longint'($urandom_range(0, 8380416));
        b  = longint'($urandom_range(0, 8380416));
        z  = longint'($urandom_range(0, 8380416));
        if ($urandom_range(0, 15) == 0) a = QM - 1;
        if ($urandom_range(0, 15) == 0) b = QM - 1;
        if ($urandom_range(0, 15) == 0) z = QM - 1;
        bt_ref(m, d2, a, b, z, ra, rb);
        step(e, m, d2, a, b, z, ra, rb);
    endtask

    task automatic directed(input bit m, input bit d2, input longint a, input longint b,
                            input longint z, input longint ea, input longint eb);
        step(1'b1, m, d2, a, b, z, ea, eb);
        idle(LAT + 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_A_out", 64'(A_out), 64'd0);
        chk("rst_B_out", 64'(B_out), 64'd0);
        reset = 1'b1;
        pipe_clear();

        directed(1'b0, 1'b0, 2, 4, 3383, 13534, 8366887);
        directed(1'b1, 1'b0, 2, 4, 3383, 6, 8373651);
        directed(1'b1, 1'b1, 2, 4, 3383, 3, 8377034);
        directed(1'b0, 1'b0, 8380416, 1, 1, 0, 8380415);
        directed(1'b0, 1'b0, 0, 8380416, 8380416, 1, 8380416);

        for (int i = 0; i < 8; i++) rnd_step(1'b1, 1'(i % 2));
        idle(LAT + 1);

        rnd_step(1'b1, 1'b0);
        rnd_step(1'b0, 1'b1);
        rnd_step(1'b1, 1'b1);
        rnd_step(1'b1, 1'b0);
        rnd_step(1'b0, 1'b0);
        idle(LAT + 1);

        for (int i = 0; i < 20000; i++)
            rnd_step(1'($urandom_range(0, 7) != 0), 1'(i % 2));
        idle(LAT + 1);

        rnd_step(1'b1, 1'b0);
        rnd_step(1'b1, 1'b1);
        rnd_step(1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", {63'd0, valid}, 64'd0);
        chk("async_A_out", 64'(A_out), 64'd0);
        chk("async_B_out", 64'(B_out), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        pipe_clear();
        idle(2);
        rnd_step(1'b1, 1'b1);
        rnd_step(1'b1, 1'b0);
        idle(LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
